mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
- Multi-cycle sequencer for the MIPS32 datapath on the FPGA. It replaces single-cycle decode with an FSM that steps each instruction through fetch, decode, execute, memory and writeback states.
- It shares one memory port between instruction fetch and data access, using a req/ready handshake with a timeout.
- It drives the PC, IR, register-file, ALU and memory-port mux controls.
- Supported instructions: R-type (including jr), lw, sw, beq, bne, addi, j, jal.

Parameters:
- MEM_TIMEOUT, 16: wait cycles allowed for mem_ready before an error is flagged. Legal range 1..255.
- TO_W, 8: width of the timeout counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- opcode  in  6  IR[31:26], valid from DECODE onward
- funct  in  6  IR[5:0]
- alu_zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write (valid with mem_req)
- iord  out  1  address select: 0 = PC, 1 = ALUOut
- ir_write  out  1  load the IR
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if (alu_zero == branch_eq)
- branch_eq  out  1  1 = beq, 0 = bne
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 register rs
- alu_src_a  out  1  0 = PC, 1 = rs
- alu_src_b  out  2  00 rt, 01 constant 4, 10 sign-extended immediate, 11 sign-extended immediate shifted left 2
- alu_op  out  2  00 add, 01 sub, 10 use funct
- reg_write  out  1  register-file write
- reg_dst  out  2  00 rt, 01 rd, 10 $31
- mem_toreg  out  2  00 ALUOut, 01 memory data register, 10 PC
- instr_done  out  1  one-cycle pulse in the final state of each instruction
- err_illegal_opcode  out  1  sticky until rst
- err_mem_timeout  out  1  sticky until rst

Behaviour:
- Reset: while rst is high at a posedge, the next state is FETCH, the timeout counter clears and both error flags clear. While rst is asserted, every output is forced to 0, combinationally. Reset in any state, including mid-handshake, abandons the instruction.
- Outputs are Moore decodes of the state. The exceptions are ir_write and pc_write in FETCH, which are gated by mem_ready.
- Unlisted outputs are 0 in every state.
- States and transitions:
  - FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. When mem_ready=1: ir_write=1, pc_write=1, go to DECODE. Otherwise stay in FETCH.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state:
    - opcode 000000 with funct 001000 → JR
    - other opcode 000000 → EXEC_R
    - 100011 or 101011 → MEM_ADR
    - 000100 or 000101 → BRANCH
    - 001000 → EXEC_I
    - 000010 → JUMP
    - 000011 → JAL
    - any other opcode → ERROR with err_illegal_opcode=1
  - EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10 → WB_R.
  - WB_R: reg_write=1, reg_dst=01, mem_toreg=00, instr_done=1 → FETCH.
  - EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=00 → WB_I.
  - WB_I: reg_write=1, reg_dst=00, mem_toreg=00, instr_done=1 → FETCH.
  - MEM_ADR: alu_src_a=1, alu_src_b=10, alu_op=00 → MEM_RD for lw, MEM_WR for sw.
  - MEM_RD: mem_req=1, iord=1. When mem_ready=1 → WB_MEM.
  - WB_MEM: reg_write=1, reg_dst=00, mem_toreg=01, instr_done=1 → FETCH.
  - MEM_WR: mem_req=1, mem_we=1, iord=1. When mem_ready=1: instr_done=1 and go to FETCH. This is a Mealy pulse.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, branch_eq=opcode[0]==0, instr_done=1 → FETCH.
  - JUMP: pc_write=1, pc_source=10, instr_done=1 → FETCH.
  - JAL: pc_write=1, pc_source=10, reg_write=1, reg_dst=10, mem_toreg=10 (PC already holds PC+4), instr_done=1 → FETCH.
  - JR: pc_write=1, pc_source=11, instr_done=1 → FETCH.
  - ERROR: all strobes 0. The block stays here until rst.
- Handshake:
  - mem_req stays high, with stable iord and mem_we, until the cycle in which mem_ready=1. That cycle completes the access.
  - mem_ready is ignored when mem_req=0.
- Timeout:
  - The counter increments each cycle that mem_req=1 and mem_ready=0.
  - It clears on completion and on every state change.
  - When the counter reaches MEM_TIMEOUT with mem_ready still 0, the next state is ERROR and err_mem_timeout=1.
  - mem_ready=1 in the same cycle that the limit is reached counts as success.
- Latency with zero-wait memory (mem_ready high on first request):
  - 3 cycles: beq, bne, j, jal, jr
  - 4 cycles: R-type, addi, sw
  - 5 cycles: lw
- Each wait cycle adds 1 to the instruction's latency.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state enum
  - opcode and funct constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J, OP_JAL, FN_JR)
  - encodings for alu_op, reg_dst, mem_toreg, pc_source and alu_src_b
- Sub-module mips_mem_timeout: the counter plus its expired output, with inputs clk, rst, active, done.

Test Plan:
- Reset, then R-type add (opcode 0, funct 100000) with mem_ready tied to 1 → states FETCH, DECODE, EXEC_R, WB_R. In WB_R: reg_write=1, reg_dst=01. instr_done on cycle 4.
- lw with mem_ready held low 3 cycles in both FETCH and MEM_RD → mem_req and iord are stable while waiting. ir_write pulses exactly once. instr_done arrives at cycle 11, and WB_MEM has mem_toreg=01.
- beq with alu_zero=1, then bne with alu_zero=1 → both take 3 cycles. branch_eq is 1 and then 0, and pc_write_cond=1 in BRANCH for both.
- jal, then jr (opcode 0, funct 001000) → jal: pc_source=10, reg_dst=10, mem_toreg=10, reg_write=1. jr: pc_source=11, reg_write=0. Check that opcode 001000 decodes to addi (EXEC_I), not jr.
- Opcode 111111 → ERROR after DECODE, err_illegal_opcode=1 sticky, and no strobes for 20 cycles. rst then returns the block to FETCH with flags clear.
- MEM_TIMEOUT=4 with mem_ready stuck at 0 in FETCH → ERROR on cycle 5 with err_mem_timeout=1. Repeat with mem_ready=1 on the 4th wait cycle → success. rst asserted mid MEM_RD → FETCH next cycle, with all outputs 0 during the rst cycle.

Source files
------------

// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared state, opcode and control-field encodings for the multi-cycle MIPS sequencer.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_MEM_ADR, S_MEM_RD,
        S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP, S_JAL, S_JR, S_ERROR
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    localparam logic [1:0] TOREG_ALU = 2'b00;
    localparam logic [1:0] TOREG_MDR = 2'b01;
    localparam logic [1:0] TOREG_PC  = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_RS     = 2'b11;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

endpackage

// File: rtl/mips_mem_timeout.sv
// Counts stalled memory-request cycles and flags expiry on the last allowed wait cycle.
// Latency: expired is combinational from the registered count and the live inputs.
// Backpressure: none; clears whenever no request is pending or the access completes.
module mips_mem_timeout
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic done,
    output logic expired
);

    localparam logic [TO_W-1:0] LIMIT = TO_W'(MEM_TIMEOUT - 1);

    logic [TO_W-1:0] cnt;

    // The cycle that would push the count to MEM_TIMEOUT is the expiry cycle.
    assign expired = active && !done && (cnt == LIMIT);

    always_ff @(posedge clk) begin
        if (rst || !active || done || expired) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS32 control FSM driving PC/IR/regfile/ALU/memory-port muxes.
// Latency: 3-5 cycles per instruction with zero-wait memory, +1 per wait cycle.
// Backpressure: mem_req held with stable iord/mem_we until mem_ready; stalls past MEM_TIMEOUT go to ERROR.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       branch_eq,
    output logic [1:0] pc_source,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_toreg,
    output logic       instr_done,
    output logic       err_illegal_opcode,
    output logic       err_mem_timeout
);

    state_t state, state_nxt;
    logic   err_ill_q, err_to_q;
    logic   set_ill, set_to;
    logic   mem_busy, tmo_expired;
    logic   unused_alu_zero;

    // The zero flag is consumed by the datapath's conditional PC-write gate.
    assign unused_alu_zero = alu_zero;

    assign mem_busy = (state inside {S_FETCH, S_MEM_RD, S_MEM_WR});

    mips_mem_timeout #(.MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(TO_W)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .active  (mem_busy),
        .done    (mem_ready),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            err_ill_q <= 1'b0;
            err_to_q  <= 1'b0;
        end else begin
            state     <= state_nxt;
            err_ill_q <= err_ill_q | set_ill;
            err_to_q  <= err_to_q | set_to;
        end
    end

    always_comb begin
        state_nxt     = state;
        set_ill       = 1'b0;
        set_to        = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_eq     = 1'b0;
        pc_source     = PCSRC_ALU;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_RT;
        alu_op        = ALU_ADD;
        reg_write     = 1'b0;
        reg_dst       = DST_RT;
        mem_toreg     = TOREG_ALU;
        instr_done    = 1'b0;

        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    state_nxt = S_DECODE;
                end else if (tmo_expired) begin
                    set_to    = 1'b1;
                    state_nxt = S_ERROR;
                end
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                case (opcode)
                    OP_RTYPE:     state_nxt = (funct == FN_JR) ? S_JR : S_EXEC_R;
                    OP_LW, OP_SW: state_nxt = S_MEM_ADR;
                    OP_BEQ, OP_BNE: state_nxt = S_BRANCH;
                    OP_ADDI:      state_nxt = S_EXEC_I;
                    OP_J:         state_nxt = S_JUMP;
                    OP_JAL:       state_nxt = S_JAL;
                    default: begin
                        set_ill   = 1'b1;
                        state_nxt = S_ERROR;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
                state_nxt = S_WB_R;
            end
            S_WB_R: begin
                reg_write  = 1'b1;
                reg_dst    = DST_RD;
                instr_done = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_EXEC_I, S_MEM_ADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                if (state == S_EXEC_I) state_nxt = S_WB_I;
                else                   state_nxt = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_WB_I: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_MEM_RD, S_MEM_WR: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = (state == S_MEM_WR);
                if (mem_ready) begin
                    instr_done = (state == S_MEM_WR);
                    state_nxt  = (state == S_MEM_WR) ? S_FETCH : S_WB_MEM;
                end else if (tmo_expired) begin
                    set_to    = 1'b1;
                    state_nxt = S_ERROR;
                end
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_toreg  = TOREG_MDR;
                instr_done = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                branch_eq     = ~opcode[0];
                instr_done    = 1'b1;
                state_nxt     = S_FETCH;
            end
            S_JUMP, S_JAL, S_JR: begin
                pc_write   = 1'b1;
                pc_source  = (state == S_JR) ? PCSRC_RS : PCSRC_JUMP;
                instr_done = 1'b1;
                state_nxt  = S_FETCH;
                if (state == S_JAL) begin
                    reg_write = 1'b1;
                    reg_dst   = DST_RA;
                    mem_toreg = TOREG_PC;
                end
            end
            S_ERROR: state_nxt = S_ERROR;
            default: state_nxt = S_FETCH;
        endcase

        // Reset silences every strobe immediately, even mid-handshake.
        if (rst) begin
            mem_req       = 1'b0;
            mem_we        = 1'b0;
            iord          = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            branch_eq     = 1'b0;
            pc_source     = 2'b00;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b00;
            alu_op        = 2'b00;
            reg_write     = 1'b0;
            reg_dst       = 2'b00;
            mem_toreg     = 2'b00;
            instr_done    = 1'b0;
        end
    end

    assign err_illegal_opcode = err_ill_q & ~rst;
    assign err_mem_timeout    = err_to_q & ~rst;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl with MEM_TIMEOUT=4; outputs sampled 1ns after the falling edge.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'b000000;
    logic [5:0] funct = 6'b100000;
    logic       alu_zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, branch_eq;
    logic [1:0] pc_source, alu_src_b, alu_op, reg_dst, mem_toreg;
    logic       alu_src_a, reg_write, instr_done, err_illegal_opcode, err_mem_timeout;

    int total = 0;
    int bad = 0;
    int irw_cnt = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.MEM_TIMEOUT(4), .TO_W(8)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .branch_eq(branch_eq), .pc_source(pc_source), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_toreg(mem_toreg), .instr_done(instr_done),
        .err_illegal_opcode(err_illegal_opcode), .err_mem_timeout(err_mem_timeout)
    );

    // {req,we,iord,irw,pcw,pcwc,beq} pcs asa asb aop rw rd mtr done
    logic [19:0] obs;
    assign obs = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, branch_eq,
                  pc_source, alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_toreg, instr_done};

    localparam logic [19:0] E_ZERO     = 20'h00000;
    localparam logic [19:0] E_FETCH_W  = {7'b1000000, 2'b00, 1'b0, 2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0};
    localparam logic [19:0] E_FETCH_R  = {7'b1001100, 2'b00, 1'b0, 2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0};
    localparam logic [19:0] E_DECODE   = {7'b0000000, 2'b00, 1'b0, 2'b11, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0};
    localparam logic [19:0] E_EXEC_R   = {7'b0000000, 2'b00, 1'b1, 2'b00, 2'b10, 1'b0, 2'b00, 2'b00, 1'b0};
    localparam logic [19:0] E_WB_R     = {7'b0000000, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 2'b01, 2'b00, 1'b1};
    localparam logic [19:0] E_EXEC_I   = {7'b0000000, 2'b00, 1'b1, 2'b10, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0};
    localparam logic [19:0] E_WB_I     = {7'b0000000, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 1'b1};
    localparam logic [19:0] E_MEM_RD   = {7'b1010000, 13'b0};
    localparam logic [19:0] E_WB_MEM   = {7'b0000000, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 2'b01, 1'b1};
    localparam logic [19:0] E_MEM_WR_W = {7'b1110000, 13'b0};
    localparam logic [19:0] E_MEM_WR_R = {7'b1110000, 12'b0, 1'b1};
    localparam logic [19:0] E_BEQ      = {7'b0000011, 2'b01, 1'b1, 2'b00, 2'b01, 1'b0, 2'b00, 2'b00, 1'b1};
    localparam logic [19:0] E_BNE      = {7'b0000010, 2'b01, 1'b1, 2'b00, 2'b01, 1'b0, 2'b00, 2'b00, 1'b1};
    localparam logic [19:0] E_JUMP     = {7'b0000100, 2'b10, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1};
    localparam logic [19:0] E_JAL      = {7'b0000100, 2'b10, 1'b0, 2'b00, 2'b00, 1'b1, 2'b10, 2'b10, 1'b1};
    localparam logic [19:0] E_JR       = {7'b0000100, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1};

    task automatic chk(input string tag, input logic [19:0] o, input logic [19:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic step(input logic r, input logic rdy, input logic [19:0] e, input string tag);
        @(negedge clk);
        rst = r;
        mem_ready = rdy;
        #1;
        if (ir_write) irw_cnt++;
        chk(tag, obs, e);
    endtask

    task automatic chk_flags(input string tag, input logic ill, input logic to);
        chk(tag, {18'b0, err_illegal_opcode, err_mem_timeout}, {18'b0, ill, to});
    endtask

    initial begin
        // Reset: outputs forced low even though mem_ready=1
        step(1, 1, E_ZERO, "reset_outputs");
        chk_flags("reset_flags", 0, 0);

        // R-type add, zero-wait: instr_done on cycle 4
        opcode = 6'b000000; funct = 6'b100000;
        step(0, 1, E_FETCH_R, "add_fetch");
        step(0, 1, E_DECODE, "add_decode");
        step(0, 1, E_EXEC_R, "add_exec");
        step(0, 1, E_WB_R, "add_wb");

        // lw with 3 wait cycles in FETCH and in MEM_RD: done on cycle 11
        opcode = 6'b100011; irw_cnt = 0;
        for (int i = 0; i < 3; i++) step(0, 0, E_FETCH_W, "lw_fetch_wait");
        step(0, 1, E_FETCH_R, "lw_fetch");
        step(0, 0, E_DECODE, "lw_decode");
        step(0, 0, E_EXEC_I, "lw_memadr");
        for (int i = 0; i < 3; i++) step(0, 0, E_MEM_RD, "lw_rd_wait");
        step(0, 1, E_MEM_RD, "lw_rd_done");
        step(0, 0, E_WB_MEM, "lw_wb");
        chk("lw_irwrite_count", 20'(irw_cnt), 20'd1);

        // sw with one wait cycle in MEM_WR
        opcode = 6'b101011;
        step(0, 1, E_FETCH_R, "sw_fetch");
        step(0, 1, E_DECODE, "sw_decode");
        step(0, 1, E_EXEC_I, "sw_memadr");
        step(0, 0, E_MEM_WR_W, "sw_wr_wait");
        step(0, 1, E_MEM_WR_R, "sw_wr_done");

        // beq then bne, alu_zero=1
        alu_zero = 1'b1; opcode = 6'b000100;
        step(0, 1, E_FETCH_R, "beq_fetch");
        step(0, 1, E_DECODE, "beq_decode");
        step(0, 1, E_BEQ, "beq_branch");
        opcode = 6'b000101;
        step(0, 1, E_FETCH_R, "bne_fetch");
        step(0, 1, E_DECODE, "bne_decode");
        step(0, 1, E_BNE, "bne_branch");
        alu_zero = 1'b0;

        // jal, jr, then addi whose opcode equals the jr funct code
        opcode = 6'b000011;
        step(0, 1, E_FETCH_R, "jal_fetch");
        step(0, 1, E_DECODE, "jal_decode");
        step(0, 1, E_JAL, "jal_exec");
        opcode = 6'b000000; funct = 6'b001000;
        step(0, 1, E_FETCH_R, "jr_fetch");
        step(0, 1, E_DECODE, "jr_decode");
        step(0, 1, E_JR, "jr_exec");
        opcode = 6'b001000; funct = 6'b001000;
        step(0, 1, E_FETCH_R, "addi_fetch");
        step(0, 1, E_DECODE, "addi_decode");
        step(0, 1, E_EXEC_I, "addi_exec");
        step(0, 1, E_WB_I, "addi_wb");

        // j
        opcode = 6'b000010;
        step(0, 1, E_FETCH_R, "j_fetch");
        step(0, 1, E_DECODE, "j_decode");
        step(0, 1, E_JUMP, "j_exec");

        // Fetch timeout: mem_ready stuck low, ERROR on cycle 5
        for (int i = 0; i < 4; i++) step(0, 0, E_FETCH_W, "to_fetch_wait");
        step(0, 0, E_ZERO, "to_error_state");
        chk_flags("to_flag_set", 0, 1);
        step(0, 1, E_ZERO, "to_error_hold");
        chk_flags("to_flag_sticky", 0, 1);
        step(1, 1, E_ZERO, "to_rst_outputs");
        chk_flags("to_rst_flags", 0, 0);

        // Ready on the 4th wait-limit cycle counts as success
        opcode = 6'b000000; funct = 6'b100000;
        for (int i = 0; i < 3; i++) step(0, 0, E_FETCH_W, "edge_fetch_wait");
        step(0, 1, E_FETCH_R, "edge_fetch_done");
        step(0, 1, E_DECODE, "edge_decode");
        step(0, 1, E_EXEC_R, "edge_exec");
        step(0, 1, E_WB_R, "edge_wb");
        chk_flags("edge_flags", 0, 0);

        // Illegal opcode: ERROR after DECODE, silent and sticky for 20 cycles
        opcode = 6'b111111;
        step(0, 1, E_FETCH_R, "ill_fetch");
        step(0, 1, E_DECODE, "ill_decode");
        for (int i = 0; i < 20; i++) begin
            step(0, logic'(i[0]), E_ZERO, "ill_error_quiet");
            chk_flags("ill_flag", 1, 0);
        end
        step(1, 0, E_ZERO, "ill_rst_outputs");
        chk_flags("ill_rst_flags", 0, 0);
        opcode = 6'b000010;
        step(0, 1, E_FETCH_R, "ill_refetch");
        step(0, 1, E_DECODE, "ill_re_decode");
        step(0, 1, E_JUMP, "ill_re_jump");

        // Reset in the middle of a MEM_RD handshake
        opcode = 6'b100011;
        step(0, 1, E_FETCH_R, "mid_fetch");
        step(0, 1, E_DECODE, "mid_decode");
        step(0, 1, E_EXEC_I, "mid_memadr");
        step(0, 0, E_MEM_RD, "mid_rd_wait");
        step(1, 1, E_ZERO, "mid_rst_outputs");
        step(0, 0, E_FETCH_W, "mid_back_to_fetch");
        chk_flags("mid_flags", 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
